// File: rtl/vending_change_dispenser.sv
// Coin-change controller: computes change or refund, pays it greedily in 20/10/5 coins
// over a pulse/ack hopper handshake, and tracks per-denomination inventory.
module vending_change_dispenser #(
    parameter logic [7:0]  INIT_COUNT  = 8'd4,
    parameter int unsigned ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       change_req,
    input  logic       refund_all,
    input  logic [7:0] sum_money,
    input  logic [7:0] price,
    input  logic       hopper_ack,
    input  logic       load_en,
    input  logic [1:0] load_deno,
    input  logic [7:0] load_count,
    output logic       deno_5,
    output logic       deno_10,
    output logic       deno_20,
    output logic       busy,
    output logic       change_done,
    output logic       change_short,
    output logic       hopper_fault,
    output logic [7:0] remaining,
    output logic [7:0] cnt_5,
    output logic [7:0] cnt_10,
    output logic [7:0] cnt_20
);

    localparam int unsigned TMR_W = ($clog2(ACK_TIMEOUT + 1) > 4) ? $clog2(ACK_TIMEOUT + 1) : 4;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    localparam logic [1:0] SEL_5  = 2'd0;
    localparam logic [1:0] SEL_10 = 2'd1;
    localparam logic [1:0] SEL_20 = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CALC     = 3'd1,
        S_SELECT   = 3'd2,
        S_ISSUE    = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [7:0] deno_value(input logic [1:0] sel);
        case (sel)
            SEL_20:  return 8'd20;
            SEL_10:  return 8'd10;
            default: return 8'd5;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       price_q, price_d;
    logic             refund_q, refund_d;
    logic [1:0]       sel_q, sel_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             deno_5_d, deno_10_d, deno_20_d;
    logic             busy_d, change_done_d, change_short_d, hopper_fault_d;
    logic [7:0]       remaining_d, cnt_5_d, cnt_10_d, cnt_20_d;

    // State and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            sum_q        <= 8'd0;
            price_q      <= 8'd0;
            refund_q     <= 1'b0;
            sel_q        <= SEL_5;
            tmr_q        <= '0;
            deno_5       <= 1'b0;
            deno_10      <= 1'b0;
            deno_20      <= 1'b0;
            busy         <= 1'b0;
            change_done  <= 1'b0;
            change_short <= 1'b0;
            hopper_fault <= 1'b0;
            remaining    <= 8'd0;
            cnt_5        <= INIT_COUNT;
            cnt_10       <= INIT_COUNT;
            cnt_20       <= INIT_COUNT;
        end else begin
            state_q      <= state_d;
            sum_q        <= sum_d;
            price_q      <= price_d;
            refund_q     <= refund_d;
            sel_q        <= sel_d;
            tmr_q        <= tmr_d;
            deno_5       <= deno_5_d;
            deno_10      <= deno_10_d;
            deno_20      <= deno_20_d;
            busy         <= busy_d;
            change_done  <= change_done_d;
            change_short <= change_short_d;
            hopper_fault <= hopper_fault_d;
            remaining    <= remaining_d;
            cnt_5        <= cnt_5_d;
            cnt_10       <= cnt_10_d;
            cnt_20       <= cnt_20_d;
        end
    end

    // Next state and next output values; pulse outputs are derived from the next state
    // so that they line up exactly with the cycle spent in that state.
    always_comb begin
        state_d        = state_q;
        sum_d          = sum_q;
        price_d        = price_q;
        refund_d       = refund_q;
        sel_d          = sel_q;
        tmr_d          = tmr_q;
        change_short_d = change_short;
        hopper_fault_d = hopper_fault;
        remaining_d    = remaining;
        cnt_5_d        = cnt_5;
        cnt_10_d       = cnt_10;
        cnt_20_d       = cnt_20;

        case (state_q)
            S_IDLE: begin
                if (change_req) begin
                    sum_d          = sum_money;
                    price_d        = price;
                    refund_d       = refund_all;
                    change_short_d = 1'b0;
                    hopper_fault_d = 1'b0;
                    state_d        = S_CALC;
                end else if (load_en) begin
                    case (load_deno)
                        2'd0:    cnt_5_d  = sat_add(cnt_5, load_count);
                        2'd1:    cnt_10_d = sat_add(cnt_10, load_count);
                        2'd2:    cnt_20_d = sat_add(cnt_20, load_count);
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (refund_q) begin
                    remaining_d = sum_q;
                end else begin
                    remaining_d = (sum_q >= price_q) ? (sum_q - price_q) : 8'd0;
                end
                state_d = S_SELECT;
            end
            S_SELECT: begin
                if (remaining == 8'd0) begin
                    state_d = S_DONE;
                end else if (remaining >= 8'd20 && cnt_20 != 8'd0) begin
                    sel_d   = SEL_20;
                    state_d = S_ISSUE;
                end else if (remaining >= 8'd10 && cnt_10 != 8'd0) begin
                    sel_d   = SEL_10;
                    state_d = S_ISSUE;
                end else if (remaining >= 8'd5 && cnt_5 != 8'd0) begin
                    sel_d   = SEL_5;
                    state_d = S_ISSUE;
                end else begin
                    change_short_d = 1'b1;
                    state_d        = S_DONE;
                end
            end
            S_ISSUE: begin
                tmr_d   = '0;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (hopper_ack) begin
                    case (sel_q)
                        SEL_20:  cnt_20_d = cnt_20 - 8'd1;
                        SEL_10:  cnt_10_d = cnt_10 - 8'd1;
                        default: cnt_5_d  = cnt_5 - 8'd1;
                    endcase
                    remaining_d = remaining - deno_value(sel_q);
                    state_d     = S_SELECT;
                end else if (tmr_q == TMR_LAST) begin
                    hopper_fault_d = 1'b1;
                    change_short_d = 1'b1;
                    state_d        = S_DONE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d        = (state_d != S_IDLE);
        change_done_d = (state_d == S_DONE);
        deno_5_d      = (state_d == S_ISSUE) && (sel_d == SEL_5);
        deno_10_d     = (state_d == S_ISSUE) && (sel_d == SEL_10);
        deno_20_d     = (state_d == S_ISSUE) && (sel_d == SEL_20);
    end

endmodule

// File: tb/tb_vending_change_dispenser.sv
// Bench for vending_change_dispenser: transaction-level timeline model checked every
// cycle, plus hand-computed expectations for each directed scenario.
module tb_vending_change_dispenser;

    localparam int ACK_TIMEOUT = 15;
    localparam int INIT        = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       change_req, refund_all, hopper_ack, load_en;
    logic [7:0] sum_money, price, load_count;
    logic [1:0] load_deno;
    logic       deno_5, deno_10, deno_20, busy, change_done, change_short, hopper_fault;
    logic [7:0] remaining, cnt_5, cnt_10, cnt_20;

    vending_change_dispenser #(.INIT_COUNT(8'd4), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n), .change_req(change_req), .refund_all(refund_all),
        .sum_money(sum_money), .price(price), .hopper_ack(hopper_ack), .load_en(load_en),
        .load_deno(load_deno), .load_count(load_count), .deno_5(deno_5), .deno_10(deno_10),
        .deno_20(deno_20), .busy(busy), .change_done(change_done), .change_short(change_short),
        .hopper_fault(hopper_fault), .remaining(remaining), .cnt_5(cnt_5), .cnt_10(cnt_10),
        .cnt_20(cnt_20)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    // Idle-state model values (index 0 = 5, 1 = 10, 2 = 20)
    int m_cnt[3];
    int m_rem;
    int m_short, m_fault;

    // Current transaction as a timeline relative to the cycle the request was sampled
    bit t_active;
    int t_n0, t_change, t_n, t_acked, t_done_rel, t_short, t_to;
    int t_coins[64];

    int pulse_log[$];
    int first_pulse_cyc, last_pulse_cyc, done_cyc, req_cyc;
    bit ack_en;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int didx(input int v);
        return (v == 20) ? 2 : (v == 10) ? 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) m_cnt[i] = INIT;
        m_rem = 0; m_short = 0; m_fault = 0; t_active = 0;
    endtask

    // Plan the whole transaction up front: greedy coin list and its fixed timeline
    task automatic model_start(input int sum, input int pr, input bit refund, input bit no_ack);
        int c[3];
        int rem, found;
        int dv[3] = '{5, 10, 20};
        c = m_cnt;
        t_change = refund ? sum : ((sum >= pr) ? sum - pr : 0);
        rem = t_change; t_n = 0; t_short = 0; t_to = 0;
        while (rem > 0) begin
            found = -1;
            for (int d = 2; d >= 0; d--) begin
                if (found < 0 && dv[d] <= rem && c[d] > 0) found = d;
            end
            if (found < 0) begin
                t_short = 1;
                break;
            end
            t_coins[t_n] = dv[found];
            t_n++;
            c[found]--;
            rem -= dv[found];
            if (no_ack) break;
        end
        t_to = (no_ack && t_n > 0) ? 1 : 0;
        t_acked = t_to ? t_n - 1 : t_n;
        if (t_to) t_short = 1;
        t_done_rel = t_to ? (3 + 3 * (t_n - 1) + ACK_TIMEOUT) : (2 + 3 * t_n);
        t_n0 = cyc + 1;
        t_active = 1;
    endtask

    task automatic compare_cycle();
        int e_busy, e_deno, e_done, e_rem, e_short, e_fault, rel, obs;
        int e_c[3];
        e_busy = 0; e_deno = 0; e_done = 0;
        e_rem = m_rem; e_c = m_cnt; e_short = m_short; e_fault = m_fault;
        if (t_active) begin
            rel = cyc - t_n0;
            if (rel >= 0) begin
                e_short = 0; e_fault = 0;
                if (rel >= 1) e_rem = t_change;
                for (int k = 0; k < t_acked; k++) begin
                    if (rel >= 4 + 3 * k) begin
                        e_rem -= t_coins[k];
                        e_c[didx(t_coins[k])]--;
                    end
                end
                for (int k = 0; k < t_n; k++) if (rel == 2 + 3 * k) e_deno = t_coins[k];
                e_busy = (rel <= t_done_rel) ? 1 : 0;
                e_done = (rel == t_done_rel) ? 1 : 0;
                if (rel >= t_done_rel) begin
                    e_short = t_short;
                    e_fault = t_to;
                end
                if (rel > t_done_rel) begin
                    m_rem = e_rem; m_cnt = e_c; m_short = e_short; m_fault = e_fault;
                    t_active = 0;
                end
            end
        end
        obs = int'(deno_5) * 5 + int'(deno_10) * 10 + int'(deno_20) * 20;
        chk("busy", int'(busy), e_busy);
        chk("deno", obs, e_deno);
        chk("change_done", int'(change_done), e_done);
        chk("remaining", int'(remaining), e_rem);
        chk("cnt_5", int'(cnt_5), e_c[0]);
        chk("cnt_10", int'(cnt_10), e_c[1]);
        chk("cnt_20", int'(cnt_20), e_c[2]);
        chk("change_short", int'(change_short), e_short);
        chk("hopper_fault", int'(hopper_fault), e_fault);
        if (obs != 0) begin
            if (pulse_log.size() == 0) first_pulse_cyc = cyc;
            pulse_log.push_back(obs);
            last_pulse_cyc = cyc;
        end
        if (change_done) done_cyc = cyc;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            compare_cycle();
        end
    end

    // Hopper: acknowledges each coin during the first cycle after its pulse
    initial begin
        hopper_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (ack_en && (deno_5 || deno_10 || deno_20)) begin
                @(posedge clk); #1 hopper_ack = 1'b1;
                @(posedge clk); #1 hopper_ack = 1'b0;
            end
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic start_txn(input int sum, input int pr, input bit refund, input bit no_ack);
        pulse_log.delete();
        ack_en = !no_ack;
        change_req = 1'b1; sum_money = 8'(sum); price = 8'(pr); refund_all = refund;
        model_start(sum, pr, refund, no_ack);
        req_cyc = t_n0;
        @(posedge clk); #1 change_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (t_active && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        chk("txn_ends_in_budget", int'(t_active), 0);
    endtask

    task automatic load(input int d, input int n);
        load_en = 1'b1; load_deno = 2'(d); load_count = 8'(n);
        @(posedge clk);
        if (!t_active && d != 3) m_cnt[d] = (m_cnt[d] + n > 255) ? 255 : m_cnt[d] + n;
        #1 load_en = 1'b0;
    endtask

    initial begin
        int k;
        reset_n = 1'b0; change_req = 1'b0; refund_all = 1'b0; sum_money = 8'd0; price = 8'd0;
        load_en = 1'b0; load_deno = 2'd0; load_count = 8'd0; ack_en = 1'b1;
        first_pulse_cyc = 0; last_pulse_cyc = 0; done_cyc = 0; req_cyc = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("reset_cnt_20", int'(cnt_20), 4);
        chk("reset_busy", int'(busy), 0);

        // Normal change 60 - 25 = 35
        start_txn(60, 25, 0, 0);
        wait_idle(100);
        chk("t1_pulses", pulse_log.size(), 3);
        if (pulse_log.size() == 3) begin
            chk("t1_coin0", pulse_log[0], 20);
            chk("t1_coin1", pulse_log[1], 10);
            chk("t1_coin2", pulse_log[2], 5);
        end
        chk("t1_latency", first_pulse_cyc - req_cyc, 2);
        chk("t1_done_at", done_cyc - req_cyc, 11);
        chk("t1_cnt_5", int'(cnt_5), 3);
        chk("t1_cnt_10", int'(cnt_10), 3);
        chk("t1_cnt_20", int'(cnt_20), 3);
        chk("t1_short", int'(change_short), 0);
        chk("t1_rem", int'(remaining), 0);

        // Cancel refund of 40
        do_reset();
        start_txn(40, 30, 1, 0);
        wait_idle(100);
        chk("t2_pulses", pulse_log.size(), 2);
        chk("t2_cnt_20", int'(cnt_20), 2);
        chk("t2_rem", int'(remaining), 0);

        // Refund of 12: one 10 then short by 2
        do_reset();
        start_txn(12, 50, 1, 0);
        wait_idle(100);
        chk("t3_pulses", pulse_log.size(), 1);
        chk("t3_short", int'(change_short), 1);
        chk("t3_rem", int'(remaining), 2);
        chk("t3_cnt_10", int'(cnt_10), 3);

        // Drain all inventory (140 = 4x20 + 4x10 + 4x5), then request 20 with nothing left
        do_reset();
        start_txn(140, 0, 1, 0);
        wait_idle(200);
        chk("t4_pulses", pulse_log.size(), 12);
        chk("t4_cnt_sum", int'(cnt_5) + int'(cnt_10) + int'(cnt_20), 0);
        start_txn(20, 0, 0, 0);
        wait_idle(100);
        chk("t4b_pulses", pulse_log.size(), 0);
        chk("t4b_short", int'(change_short), 1);
        chk("t4b_rem", int'(remaining), 20);

        // Underpay: no coins, done three edges after the request
        do_reset();
        start_txn(10, 25, 0, 0);
        wait_idle(100);
        chk("t5_pulses", pulse_log.size(), 0);
        chk("t5_done_at", done_cyc - (req_cyc - 1), 3);
        chk("t5_rem", int'(remaining), 0);

        // Hopper never acks
        do_reset();
        start_txn(5, 0, 0, 1);
        wait_idle(100);
        chk("t6_pulses", pulse_log.size(), 1);
        chk("t6_fault_delay", done_cyc - last_pulse_cyc, ACK_TIMEOUT + 1);
        chk("t6_fault", int'(hopper_fault), 1);
        chk("t6_short", int'(change_short), 1);
        chk("t6_cnt_5", int'(cnt_5), 4);
        chk("t6_rem", int'(remaining), 5);
        start_txn(5, 0, 0, 0);
        wait_idle(100);
        chk("t6b_fault_cleared", int'(hopper_fault), 0);
        chk("t6b_cnt_5", int'(cnt_5), 3);

        // Refill with saturation, ignored target 3, and loads/requests while busy
        do_reset();
        load(2, 253);
        chk("t7_sat", int'(cnt_20), 255);
        load(0, 3);
        chk("t7_cnt_5", int'(cnt_5), 7);
        load(3, 10);
        chk("t7_ignored", int'(cnt_10), 4);
        start_txn(60, 25, 0, 0);
        @(posedge clk); #1;
        load_en = 1'b1; load_deno = 2'd1; load_count = 8'd50;
        change_req = 1'b1; sum_money = 8'd200; price = 8'd0;
        @(posedge clk); #1 load_en = 1'b0; change_req = 1'b0;
        wait_idle(100);
        chk("t7_pulses", pulse_log.size(), 3);
        chk("t7_cnt_20", int'(cnt_20), 254);
        chk("t7_cnt_10", int'(cnt_10), 3);
        chk("t7_cnt_5", int'(cnt_5), 6);

        // Reset while waiting for the hopper
        start_txn(60, 25, 0, 0);
        k = 0;
        while (pulse_log.size() == 0 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("t8_pulse_seen", pulse_log.size(), 1);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        chk("t8_busy", int'(busy), 0);
        chk("t8_cnt_20", int'(cnt_20), 4);
        chk("t8_rem", int'(remaining), 0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (4) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got %0d of %0d checks passing", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
